ysyx_22050612_mem_responder: RTL and testbench
==============================================

# ysyx_22050612_mem_responder

Memory-side responder for the core's load/store path: accepts one request at a time on a valid/ready request channel and returns read data or a write acknowledgement on a valid/ready response channel after a fixed, parameterised latency. It backs a word-organised, byte-maskable 64-bit storage array. It sits opposite the execute stage's memory initiator, replacing direct pmem access with a synthesizable, latency-bearing target.

## Interface
- `BASE`, default 64'h8000_0000: first byte address served.
- `DEPTH_LOG2`, default 10: log2 of the number of 64-bit words stored.
- `LATENCY`, default 2, legal range 1..15: cycles from request handshake to `rsp_valid`.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder can accept.
- `req_addr`, input, 64: byte address. Bits [2:0] are ignored.
- `req_wen`, input, 1: 1 for a store, 0 for a load.
- `req_wdata`, input, 64: store data, lane-aligned.
- `req_wmask`, input, 8: byte enables; bit i enables byte lane i.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: initiator accepts the response.
- `rsp_rdata`, output, 64: full aligned word. Sign/zero extension and lane selection are done by the initiator.
- `rsp_err`, output, 1: address outside [BASE, BASE + 8·2^DEPTH_LOG2).

## Operation
- FSM states: IDLE, BUSY, RESP. One transaction is outstanding at most.
- `req_ready` is 1 only in IDLE. `rsp_valid` is 1 only in RESP. Both are decoded from the state register.
- **IDLE:** on `req_valid & req_ready`, latch addr, wen, wdata and wmask, and load the counter with LATENCY-1.
  - If LATENCY==1, go straight to the commit step. Otherwise go to BUSY.
- **BUSY:** decrement the counter each cycle. On the edge where the counter is 0, commit and go to RESP.
- **Commit**, a single edge:
  - Compute word index = (addr − BASE)[DEPTH_LOG2+2:3].
  - In range and wen=1: write each byte lane whose wmask bit is set. `rsp_rdata` = 0.
  - In range and wen=0: `rsp_rdata` = array[index].
  - Out of range: no write, `rsp_rdata` = 0, `rsp_err` = 1. Otherwise `rsp_err` = 0.
- **RESP:** hold `rsp_rdata` and `rsp_err` stable until `rsp_valid & rsp_ready`, then go to IDLE.
- A new request cannot be accepted in the same cycle as a response handshake. `req_ready` rises the following cycle.
- A store with wmask=0 leaves memory unchanged and still produces a response.
- Array contents are not reset.

## Timing
- **Reset (async assert):**
  - state = IDLE, counter = 0.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- **Reset mid-transaction:**
  - Before commit: the transaction is dropped and memory is untouched.
  - After commit: the write persists and the response is dropped.
- **Latency:** request handshake at edge T gives `rsp_valid` = 1 from edge T+LATENCY.
  - With `rsp_ready` held at 1, the response handshake occurs at edge T+LATENCY+1, and the next accept is possible at edge T+LATENCY+2.
  - Peak throughput is one transaction per LATENCY+2 cycles.
- **Ordering:** a load issued after a store completes always returns the stored data, because commits are strictly sequential.
- **Backpressure:** `rsp_ready` = 0 holds RESP indefinitely. `req_valid` has no effect outside IDLE.
- **Address arithmetic:** the range check is 64-bit unsigned, with no wrap-around. An address below BASE is out of range.

## Structure
- **Package `ysyx_22050612_mem_pkg`:**
  - State enum: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Default BASE constant.
  - Word width (64) and mask width (8) constants.
- **Sub-module `ysyx_22050612_sram_array`:**
  - 2^DEPTH_LOG2 × 64 storage.
  - Synchronous byte-masked write and synchronous read, both enabled by a commit strobe.
  - No reset.
- The top level holds the FSM, the counter, the request latch, the range check and the response registers.

## Test plan
- **Store then load:** store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF; then load the same address. Expect `rsp_rdata` = 0x1122334455667788, `rsp_err` = 0, and `rsp_valid` exactly LATENCY cycles after each accept.
- **Partial mask:** store 0xFFFF_FFFF_FFFF_FFFF with wmask 0xF0 to a word already holding 0x1122334455667788. A load returns 0xFFFFFFFF55667788.
- **Out of range:** load addr 0x7FFF_FFF8 and addr BASE+8·2^DEPTH_LOG2. Expect `rsp_err` = 1 and `rsp_rdata` = 0. A store to the same out-of-range addresses leaves a previously written in-range word unchanged.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles during RESP. `rsp_valid` and `rsp_rdata` stay stable, `req_ready` stays 0, and a `req_valid` pulse during this window is ignored.
- **Reset mid-BUSY (LATENCY=4):** assert `rst_n` low 1 cycle after accepting a store. The outputs take their reset values immediately, and a later load shows the old data.
- **LATENCY=1 back-to-back:** with `req_valid` and `rsp_ready` held at 1, accepts occur every 3 cycles.

Source files
------------

// File: rtl/ysyx_22050612_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_mem_pkg
// Description : Shared types and constants for the memory responder slice.
// Revision    : 1.0 - initial release
// ============================================================================

package ysyx_22050612_mem_pkg;

    localparam int          c_word_w       = 64;
    localparam int          c_mask_w       = c_word_w / 8;
    localparam logic [63:0] c_default_base = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050612_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_sram_array
// Description : 2^DEPTH_LOG2 x 64-bit storage, byte-masked sync write, sync read.
// Revision    : 1.0 - initial release
// ============================================================================

module ysyx_22050612_sram_array
    import ysyx_22050612_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  wen,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [c_word_w-1:0]   wdata,
    input  logic [c_mask_w-1:0]   wmask,
    output logic [c_word_w-1:0]   rdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [c_word_w-1:0] r_mem [c_depth];
    logic [c_word_w-1:0] r_rdata;

    // Contents are deliberately left unreset so the array maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int i = 0; i < c_mask_w; i++) begin
                    if (wmask[i]) begin
                        r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050612_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_mem_responder
// Description : Single-outstanding load/store target with fixed response latency.
// Revision    : 1.0 - initial release
// ============================================================================

module ysyx_22050612_mem_responder
    import ysyx_22050612_mem_pkg::*;
#(
    parameter logic [63:0] BASE       = c_default_base,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_addr,
    input  logic                req_wen,
    input  logic [c_word_w-1:0] req_wdata,
    input  logic [c_mask_w-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [c_word_w-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam logic [3:0]  c_cnt_load  = 4'(LATENCY - 1);
    localparam logic [63:0] c_span      = 64'd8 << DEPTH_LOG2;
    localparam logic [63:0] c_lane_bits = 64'h7;

    state_e                r_state;
    state_e                w_state_next;
    logic [3:0]            r_cnt;
    logic [63:0]           r_addr;
    logic                  r_wen;
    logic [c_word_w-1:0]   r_wdata;
    logic [c_mask_w-1:0]   r_wmask;
    logic                  r_rsp_err;
    logic                  r_rsp_load;

    logic                  w_accept;
    logic                  w_commit;
    logic [63:0]           w_addr_al;
    logic [63:0]           w_offset;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [c_word_w-1:0]   w_sram_rdata;

    assign w_accept = req_valid & req_ready;
    // LATENCY==1 loads a zero count, so BUSY lasts exactly one edge: the commit.
    assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)     w_state_next = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_state_next = RESP;
            RESP:    if (rsp_ready)     w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_cnt_load;
            r_addr  <= req_addr;
            r_wen   <= req_wen;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
        end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Unsigned 64-bit check; the lower-bound test stops a wrapped offset passing.
    assign w_addr_al  = r_addr & ~c_lane_bits;
    assign w_offset   = w_addr_al - BASE;
    assign w_in_range = (w_addr_al >= BASE) && (w_offset < c_span);
    assign w_index    = w_offset[DEPTH_LOG2+2:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
        end else if (w_commit) begin
            r_rsp_err  <= ~w_in_range;
            r_rsp_load <= w_in_range & ~r_wen;
        end
    end

    ysyx_22050612_sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (w_commit),
        .wen   (r_wen & w_in_range),
        .addr  (w_index),
        .wdata (r_wdata),
        .wmask (r_wmask),
        .rdata (w_sram_rdata)
    );

    // The array read port only moves on a commit, so gating it holds data through RESP.
    assign rsp_rdata = r_rsp_load ? w_sram_rdata : '0;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050612_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050612_mem_responder
// Description : Directed bench over LATENCY=2, 4 and 1 responder instances.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ysyx_22050612_mem_responder;

    localparam logic [63:0] c_base = 64'h8000_0000;
    localparam logic [63:0] c_end  = 64'h8000_2000;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [63:0] req_addr  [3];
    logic        req_wen   [3];
    logic [63:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [63:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mem_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wen(req_wen[0]), .req_wdata(req_wdata[0]),
        .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_22050612_mem_responder #(.LATENCY(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wen(req_wen[1]), .req_wdata(req_wdata[1]),
        .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    ysyx_22050612_mem_responder #(.LATENCY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_wen(req_wen[2]), .req_wdata(req_wdata[2]),
        .req_wmask(req_wmask[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the response handshake.
    task automatic txn(input int d, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       output logic [63:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("req_ready_timeout", 64'd0, 64'd1);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = mask;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("rsp_valid_timeout", 64'd0, 64'd1);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          acc [$];
        int          guard;

        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_wen[d]   = 1'b0;
            req_wdata[d] = '0;
            req_wmask[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 64'd0);
        check("rst_rsp_err",   64'(rsp_err[0]), 64'd0);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(posedge clk); #1;

        // Store then load, LATENCY=2
        txn(0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat);
        check("st_lat", 64'(lat), 64'd2);
        check("st_err", 64'(er), 64'd0);
        check("st_rdata", rd, 64'd0);
        txn(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        check("ld_lat", 64'(lat), 64'd2);
        check("ld_err", 64'(er), 64'd0);
        check("ld_rdata", rd, 64'h1122334455667788);

        // Partial mask, low address bits ignored on the load
        txn(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, rd, er, lat);
        txn(0, 1'b0, 64'h8000_0015, 64'd0, 8'h00, rd, er, lat);
        check("pmask_rdata", rd, 64'hFFFFFFFF55667788);

        // Out of range below BASE and at BASE+span
        txn(0, 1'b1, c_base, 64'hA5A5_0000_5A5A_0001, 8'hFF, rd, er, lat);
        txn(0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, rd, er, lat);
        check("oor_lo_err", 64'(er), 64'd1);
        check("oor_lo_rdata", rd, 64'd0);
        txn(0, 1'b0, c_end, 64'd0, 8'h00, rd, er, lat);
        check("oor_hi_err", 64'(er), 64'd1);
        check("oor_hi_rdata", rd, 64'd0);
        txn(0, 1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er, lat);
        check("oor_st_lo_err", 64'(er), 64'd1);
        txn(0, 1'b1, c_end, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er, lat);
        check("oor_st_hi_err", 64'(er), 64'd1);
        txn(0, 1'b0, c_base, 64'd0, 8'h00, rd, er, lat);
        check("oor_keep_w0", rd, 64'hA5A5_0000_5A5A_0001);
        check("oor_keep_w0_err", 64'(er), 64'd0);
        txn(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        check("oor_keep_w2", rd, 64'hFFFFFFFF55667788);

        // Backpressure: response held 5 cycles, stray request ignored
        req_valid[0] = 1'b1;
        req_wen[0]   = 1'b0;
        req_addr[0]  = 64'h8000_0010;
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        guard = 0;
        while (!rsp_valid[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_reached_resp", 64'(rsp_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid[0] = 1'b1;
                req_wen[0]   = 1'b1;
                req_wdata[0] = 64'd0;
                req_wmask[0] = 8'hFF;
            end
            check("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
            check("bp_rsp_rdata", rsp_rdata[0], 64'hFFFFFFFF55667788);
            check("bp_req_ready", 64'(req_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 64'(rsp_valid[0]), 64'd0);
        check("bp_idle_ready", 64'(req_ready[0]), 64'd1);
        txn(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        check("bp_store_ignored", rd, 64'hFFFFFFFF55667788);

        // Reset mid-BUSY, LATENCY=4
        txn(1, 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
        check("l4_st_lat", 64'(lat), 64'd4);
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b1;
        req_addr[1]  = 64'h8000_0020;
        req_wdata[1] = 64'hCAFE_CAFE_CAFE_CAFE;
        req_wmask[1] = 8'hFF;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("l4_busy_ready", 64'(req_ready[1]), 64'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        check("l4_rst_req_ready", 64'(req_ready[1]), 64'd1);
        check("l4_rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        check("l4_rst_rsp_rdata", rsp_rdata[1], 64'd0);
        check("l4_rst_rsp_err",   64'(rsp_err[1]), 64'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        txn(1, 1'b0, 64'h8000_0020, 64'd0, 8'h00, rd, er, lat);
        check("l4_old_data", rd, 64'h0123_4567_89AB_CDEF);
        check("l4_ld_lat", 64'(lat), 64'd4);

        // LATENCY=1 back-to-back with zero-mask stores
        txn(2, 1'b1, 64'h8000_0008, 64'h5555_AAAA_3333_CCCC, 8'hFF, rd, er, lat);
        check("l1_st_lat", 64'(lat), 64'd1);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b1;
        req_addr[2]  = 64'h8000_0008;
        req_wdata[2] = 64'd0;
        req_wmask[2] = 8'h00;
        rsp_ready[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready[2]) acc.push_back(c);
            @(posedge clk); #1;
        end
        req_valid[2] = 1'b0;
        check("l1_b2b_count", 64'(acc.size()), 64'd4);
        for (int i = 1; i < acc.size(); i++) begin
            check("l1_b2b_gap", 64'(acc[i] - acc[i-1]), 64'd3);
        end
        txn(2, 1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er, lat);
        check("l1_mask0_keep", rd, 64'h5555_AAAA_3333_CCCC);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
